axi_rd_arbiter_2x1: RTL and testbench
=====================================

Name: axi_rd_arbiter_2x1

Overview:
- Shares one AXI4 read-only master port between two AXI4 read requesters: s0 is the instruction-fetch path and s1 is the data/refill path.
- Sits in front of the crossbar slave port of the SoC.
- Round-robin grant, one burst outstanding at a time, R beats routed back to the granted requester only.
- Checks beat count against ARLEN and flags mismatches.

Parameters:
- ADDR_W, 32, address width for araddr on all ports
- DATA_W, 32, R data width on all ports

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- s0_arvalid  in  1  requester 0 address valid
- s0_arready  out  1  requester 0 address accepted
- s0_araddr  in  ADDR_W  requester 0 address
- s0_arlen  in  8  requester 0 burst length minus 1
- s0_arsize  in  3  requester 0 beat size
- s0_arburst  in  2  requester 0 burst type
- s0_rvalid  out  1  requester 0 read data valid
- s0_rready  in  1  requester 0 read data ready
- s0_rdata  out  DATA_W  requester 0 read data
- s0_rresp  out  2  requester 0 read response
- s0_rlast  out  1  requester 0 last beat
- s1_*  (same set as s0_*)  requester 1 ports, identical widths and directions
- m_arvalid  out  1  master address valid
- m_arready  in  1  master address accepted
- m_araddr  out  ADDR_W  master address
- m_arlen  out  8  master burst length minus 1
- m_arsize  out  3  master beat size
- m_arburst  out  2  master burst type
- m_rvalid  in  1  master read data valid
- m_rready  out  1  master read data ready
- m_rdata  in  DATA_W  master read data
- m_rresp  in  2  master read response
- m_rlast  in  1  master last beat
- len_err  out  1  one-cycle pulse on beat-count mismatch
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, last_grant=1 (so s0 wins the first tie), all arready/rvalid/m_arvalid/m_rready/len_err=0, beat_cnt=0.
- IDLE:
  - Grant selection when only one sN_arvalid is high: grant goes to that requester.
  - Grant selection when both are high: grant goes to the requester that is not last_grant.
  - The granted sN_arready is driven high combinationally in the same cycle. This is the only state in which arready can be 1.
  - On that handshake, register addr/len/size/burst and grant, clear beat_cnt, move to AR.
  - With no arvalid, stay in IDLE and drive all arready low.
- AR:
  - m_arvalid=1, driven only from registered fields; the master AR channel has no combinational path from the sN inputs.
  - Fields are held stable until m_arready.
  - On m_arvalid&&m_arready, move to R.
  - Added latency: one cycle from requester handshake to m_arvalid.
- R:
  - m_rready = sG_rready, where G is the registered grant.
  - sG_rvalid = m_rvalid. rdata, rresp and rlast pass through combinationally.
  - The non-granted requester sees rvalid=0 and rlast=0; its rdata and rresp are don't-care and are driven 0.
  - Each beat (m_rvalid&&m_rready) increments beat_cnt (9-bit, no wrap possible since len ≤ 255).
  - On a beat with m_rlast=1:
    - pulse len_err if beat_cnt != reg_len (the count before increment);
    - set last_grant=G;
    - return to IDLE.
  - A beat where beat_cnt==reg_len but m_rlast=0: pulse len_err on that beat and stay in R until rlast. Consumption is not truncated.
- Back-to-back: a new grant can be taken in the IDLE cycle right after the rlast beat. There are no combinational paths from m_r* to sN_arready.
- Simultaneous arvalid arriving in the same cycle as the rlast beat is not seen until IDLE (next cycle).
- Requester deasserting arvalid before its handshake is an AXI violation and is not handled.
- rresp is passed through unmodified. SLVERR/DECERR do not alter sequencing.
- Reset mid-burst:
  - Return to IDLE immediately and drop all valids.
  - Any outstanding downstream burst is abandoned. Downstream shares rst, so this is legal.

Decomposition:
- Shared package axi_rd_arb_pkg holds:
  - state enum {IDLE, AR, R};
  - AXI constants BURST_FIXED/INCR/WRAP, RESP_OKAY/EXOKAY/SLVERR/DECERR.
- Sub-module rr_arb2 holds the 2-way round-robin grant: req[1:0], last_grant, grant, grant_valid; purely combinational.
- The FSM, field registers, beat counter and R mux stay in the top module.

Test Plan:
- Single s0 burst: s0 arvalid, addr=0x0000_0100, len=3 → m_arvalid one cycle after s0_arready with same fields; 4 beats 0xA0..0xA3 reach s0 only, s0_rlast on 4th, len_err=0, s1_rvalid stays 0.
- Simultaneous requests from reset: s0 and s1 arvalid together (s0 addr=0xFFFE0000 len=0, s1 addr=0x40 len=1) → s0 served first, then s1; a second simultaneous pair → s1 served first (alternation).
- Backpressure:
  - m_arready held low 5 cycles → m_ar* stable throughout, no second arready;
  - s1_rready toggled → m_rready mirrors it, no beats lost or duplicated.
- Early rlast: len=3, master sends rlast on beat 2 → len_err pulse exactly on that beat, FSM returns to IDLE.
- Late rlast: len=1, rlast on beat 3 → len_err on beat 2, FSM stays in R, returns to IDLE after beat 3.
- Reset during R after 2 of 4 beats → next cycle busy=0, all valids 0, last_grant=1; a fresh s1-only request is granted normally.

Source files
------------

// File: rtl/axi_rd_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_rd_arb_pkg
// Purpose  : Shared state encoding, AXI constants and beat-count helper for
//            the 2:1 AXI read arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } arb_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // cnt is the number of beats already accepted before the current one.
  // A last beat must land exactly on index len; a non-last beat on index len
  // means the master is running past the requested length.
  function automatic logic beat_len_error(input logic [8:0] cnt,
                                          input logic [7:0] len,
                                          input logic       last);
    logic w_on_len;
    w_on_len = (cnt == {1'b0, len});
    return last ? !w_on_len : w_on_len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_rd_arbiter_2x1_rr_arb2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin grant selection, purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req;
    grant       = 1'b0;
    unique case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi_rd_arbiter_2x1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter_2x1
// Purpose  : Shares one AXI4 read master port between instruction-fetch (s0)
//            and data/refill (s1) requesters, one burst in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter_2x1
  import axi_rd_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0
  input  logic              s0_arvalid,
  output logic              s0_arready,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0]        s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  // requester 1
  input  logic              s1_arvalid,
  output logic              s1_arready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0]        s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  // master
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  // status
  output logic              len_err,
  output logic              busy
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_last_grant;
  logic              r_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic [8:0]        r_beat_cnt;

  logic              w_arb_grant;
  logic              w_arb_valid;
  logic              w_req_hs;
  logic              w_beat;
  logic              w_in_r;

  rr_arb2 u_rr_arb2 (
    .req         ({s1_arvalid, s0_arvalid}),
    .last_grant  (r_last_grant),
    .grant       (w_arb_grant),
    .grant_valid (w_arb_valid)
  );

  // arready is a function of state and arvalid only, so every arready is a
  // completed handshake in the same cycle.
  assign w_req_hs = (r_state == IDLE) && w_arb_valid;
  assign w_in_r   = (r_state == R);
  assign w_beat   = w_in_r && m_rvalid && m_rready;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_req_hs)               w_state_nxt = AR;
      AR:      if (m_arready)              w_state_nxt = R;
      R:       if (w_beat && m_rlast)      w_state_nxt = IDLE;
      default:                             w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_addr       <= '0;
      r_len        <= '0;
      r_size       <= '0;
      r_burst      <= '0;
      r_beat_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_hs) begin
        r_grant    <= w_arb_grant;
        r_addr     <= w_arb_grant ? s1_araddr  : s0_araddr;
        r_len      <= w_arb_grant ? s1_arlen   : s0_arlen;
        r_size     <= w_arb_grant ? s1_arsize  : s0_arsize;
        r_burst    <= w_arb_grant ? s1_arburst : s0_arburst;
        r_beat_cnt <= '0;
      end
      if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + 9'd1;
        if (m_rlast) r_last_grant <= r_grant;
      end
    end
  end

  // Master AR channel is driven only from the captured fields.
  assign m_arvalid  = (r_state == AR);
  assign m_araddr   = r_addr;
  assign m_arlen    = r_len;
  assign m_arsize   = r_size;
  assign m_arburst  = r_burst;

  assign s0_arready = w_req_hs && !w_arb_grant;
  assign s1_arready = w_req_hs &&  w_arb_grant;

  always_comb begin
    m_rready  = 1'b0;
    s0_rvalid = 1'b0;
    s0_rdata  = '0;
    s0_rresp  = '0;
    s0_rlast  = 1'b0;
    s1_rvalid = 1'b0;
    s1_rdata  = '0;
    s1_rresp  = '0;
    s1_rlast  = 1'b0;
    if (w_in_r) begin
      if (r_grant) begin
        m_rready  = s1_rready;
        s1_rvalid = m_rvalid;
        s1_rdata  = m_rdata;
        s1_rresp  = m_rresp;
        s1_rlast  = m_rlast;
      end else begin
        m_rready  = s0_rready;
        s0_rvalid = m_rvalid;
        s0_rdata  = m_rdata;
        s0_rresp  = m_rresp;
        s0_rlast  = m_rlast;
      end
    end
  end

  assign len_err = w_beat && beat_len_error(r_beat_cnt, r_len, m_rlast);
  assign busy    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter_2x1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_arbiter_2x1
// Purpose  : Self-checking bench: directed vector table, abort/reset sequence
//            and randomized traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter_2x1;
  import axi_rd_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
  logic [31:0] s0_araddr, s0_rdata;
  logic [7:0]  s0_arlen;
  logic [2:0]  s0_arsize;
  logic [1:0]  s0_arburst, s0_rresp;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
  logic [31:0] s1_araddr, s1_rdata;
  logic [7:0]  s1_arlen;
  logic [2:0]  s1_arsize;
  logic [1:0]  s1_arburst, s1_rresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [31:0] m_araddr, m_rdata;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_rresp;
  logic        len_err, busy;

  always #5 clk = ~clk;

  axi_rd_arbiter_2x1 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
    .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata),
    .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
    .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata),
    .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .len_err(len_err), .busy(busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          nbeats;   // beats the downstream master will actually return
  } req_t;

  typedef struct {
    bit pre_reset;
    bit v0; logic [31:0] a0; int l0; int n0;
    bit v1; logic [31:0] a1; int l1; int n1;
    int ar_stall; int rr_mode;
    int exp_n; int exp_o0; int exp_o1;
    int exp_errs; int exp_b0; int exp_b1;
  } vec_t;

  int total = 0;
  int bad   = 0;

  req_t rq0[$], rq1[$];
  int   order_log[$];

  // transaction-level model of the arbiter
  bit   mdl_out, mdl_ar_done;
  int   mdl_last, cur_who, cur_cnt;
  req_t cur;

  // downstream master / requester stimulus state
  bit mst_active, last_hb;
  int mst_idx, mst_n, burst_no;
  int rv_prob, ar_prob, rr_mode, ar_stall_left;

  int err_cnt, beats0, beats1, beat_total, exp_beats;
  bit f_h0, f_h1, f_hm, f_hb, f_rlast;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic req_t mk_req(input logic [31:0] a, input int l, input int n);
    req_t r;
    r.addr = a; r.len = 8'(l); r.size = 3'd2; r.burst = BURST_INCR; r.nbeats = n;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.addr  = $urandom;
    r.len   = 8'($urandom_range(0, 15));
    r.size  = 3'($urandom_range(0, 7));
    r.burst = 2'($urandom_range(0, 2));
    if ($urandom_range(0, 9) == 0) r.nbeats = $urandom_range(1, int'(r.len) + 3);
    else                           r.nbeats = int'(r.len) + 1;
    return r;
  endfunction

  function automatic vec_t mkv(bit pr, bit v0, logic [31:0] a0, int l0, int n0,
                               bit v1, logic [31:0] a1, int l1, int n1,
                               int st, int rm, int en, int o0, int o1,
                               int er, int b0, int b1);
    vec_t v;
    v.pre_reset = pr;
    v.v0 = v0; v.a0 = a0; v.l0 = l0; v.n0 = n0;
    v.v1 = v1; v.a1 = a1; v.l1 = l1; v.n1 = n1;
    v.ar_stall = st; v.rr_mode = rm;
    v.exp_n = en; v.exp_o0 = o0; v.exp_o1 = o1;
    v.exp_errs = er; v.exp_b0 = b0; v.exp_b1 = b1;
    return v;
  endfunction

  task automatic drive_inputs();
    s0_arvalid = (rq0.size() != 0);
    if (s0_arvalid) begin
      s0_araddr = rq0[0].addr; s0_arlen = rq0[0].len;
      s0_arsize = rq0[0].size; s0_arburst = rq0[0].burst;
    end else begin
      s0_araddr = '0; s0_arlen = '0; s0_arsize = '0; s0_arburst = '0;
    end
    s1_arvalid = (rq1.size() != 0);
    if (s1_arvalid) begin
      s1_araddr = rq1[0].addr; s1_arlen = rq1[0].len;
      s1_arsize = rq1[0].size; s1_arburst = rq1[0].burst;
    end else begin
      s1_araddr = '0; s1_arlen = '0; s1_arsize = '0; s1_arburst = '0;
    end
    if (m_arvalid) begin
      if (ar_stall_left > 0) begin
        m_arready = 1'b0;
        ar_stall_left--;
      end else begin
        m_arready = ($urandom_range(0, 99) < ar_prob);
      end
    end else begin
      m_arready = 1'b0;
    end
    // an offered beat stays put until it is taken
    if (!(m_rvalid && !last_hb)) begin
      if (mst_active && ($urandom_range(0, 99) < rv_prob)) begin
        m_rvalid = 1'b1;
        m_rdata  = 32'hA0 + 32'(mst_idx) + 32'(burst_no) * 32'h100;
        m_rresp  = 2'($urandom_range(0, 3));
        m_rlast  = (mst_idx == mst_n - 1);
      end else begin
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rdata  = '0;
        m_rresp  = '0;
      end
    end
    case (rr_mode)
      0:       begin s0_rready = 1'b1;        s1_rready = 1'b1;        end
      1:       begin s0_rready = ~s0_rready;  s1_rready = ~s1_rready;  end
      default: begin
        s0_rready = ($urandom_range(0, 3) != 0);
        s1_rready = ($urandom_range(0, 3) != 0);
      end
    endcase
  endtask

  task automatic check_cycle();
    logic exp_a0, exp_a1, exp_err;
    exp_a0 = 1'b0; exp_a1 = 1'b0;
    if (!mdl_out) begin
      if (s0_arvalid && s1_arvalid) begin
        if (mdl_last == 1) exp_a0 = 1'b1; else exp_a1 = 1'b1;
      end else if (s0_arvalid) exp_a0 = 1'b1;
      else if (s1_arvalid)     exp_a1 = 1'b1;
      check("s0_arready", s0_arready, exp_a0);
      check("s1_arready", s1_arready, exp_a1);
      check("busy_idle", busy, 0);
      check("m_arvalid_idle", m_arvalid, 0);
      check("m_rready_idle", m_rready, 0);
      check("rvalid_idle", {s0_rvalid, s1_rvalid}, 0);
    end else begin
      check("arready_busy", {s0_arready, s1_arready}, 0);
      check("busy", busy, 1);
      if (!mdl_ar_done) begin
        check("m_arvalid", m_arvalid, 1);
        check("m_araddr", m_araddr, cur.addr);
        check("m_arlen", m_arlen, cur.len);
        check("m_arsize", m_arsize, cur.size);
        check("m_arburst", m_arburst, cur.burst);
        check("m_rready_ar", m_rready, 0);
      end else begin
        check("m_arvalid_r", m_arvalid, 0);
        check("m_rready", m_rready, (cur_who == 1) ? s1_rready : s0_rready);
        if (cur_who == 0) begin
          check("s0_rvalid", s0_rvalid, m_rvalid);
          check("s1_quiet", {s1_rvalid, s1_rlast, s1_rdata}, 0);
          if (m_rvalid) check("s0_rbeat", {s0_rdata, s0_rresp, s0_rlast},
                              {m_rdata, m_rresp, m_rlast});
        end else begin
          check("s1_rvalid", s1_rvalid, m_rvalid);
          check("s0_quiet", {s0_rvalid, s0_rlast, s0_rdata}, 0);
          if (m_rvalid) check("s1_rbeat", {s1_rdata, s1_rresp, s1_rlast},
                              {m_rdata, m_rresp, m_rlast});
        end
      end
    end
    f_hb = m_rvalid && m_rready;
    exp_err = 1'b0;
    if (mdl_out && mdl_ar_done && f_hb)
      exp_err = m_rlast ? (cur_cnt != int'(cur.len)) : (cur_cnt == int'(cur.len));
    check("len_err", len_err, exp_err);
    if (len_err) err_cnt++;
    f_h0    = s0_arvalid && s0_arready;
    f_h1    = s1_arvalid && s1_arready;
    f_hm    = m_arvalid && m_arready;
    f_rlast = m_rlast;
  endtask

  task automatic update();
    if (f_h0) begin
      order_log.push_back(0); cur = rq0.pop_front(); cur_who = 0;
      mdl_out = 1'b1; mdl_ar_done = 1'b0; cur_cnt = 0;
    end
    if (f_h1) begin
      order_log.push_back(1); cur = rq1.pop_front(); cur_who = 1;
      mdl_out = 1'b1; mdl_ar_done = 1'b0; cur_cnt = 0;
    end
    if (f_hm) begin
      mdl_ar_done = 1'b1; mst_active = 1'b1; mst_idx = 0; mst_n = cur.nbeats;
    end
    if (f_hb) begin
      cur_cnt++; beat_total++; mst_idx++;
      if (cur_who == 0) beats0++; else beats1++;
      if (f_rlast) begin
        mdl_out = 1'b0; mdl_last = cur_who; mst_active = 1'b0; burst_no++;
      end
    end
    last_hb = f_hb;
  endtask

  task automatic run_engine(input int budget, input int max_beats, input int arrive_cycles);
    int cyc;
    bit done;
    cyc = 0; done = 1'b0;
    drive_inputs();
    while (!done) begin
      @(negedge clk); check_cycle();
      @(posedge clk); #1; update();
      cyc++;
      if (cyc < arrive_cycles) begin
        req_t r;
        if ($urandom_range(0, 99) < 6) begin r = rand_req(); rq0.push_back(r); exp_beats += r.nbeats; end
        if ($urandom_range(0, 99) < 6) begin r = rand_req(); rq1.push_back(r); exp_beats += r.nbeats; end
      end
      if (max_beats > 0 && beat_total >= max_beats) done = 1'b1;
      else if (rq0.size() == 0 && rq1.size() == 0 && !mdl_out && cyc >= arrive_cycles) done = 1'b1;
      else if (cyc >= budget) begin
        total++; bad++;
        $display("FAIL engine_timeout: cycles=%0d budget=%0d pending=%0d/%0d", cyc, budget,
                 rq0.size(), rq1.size());
        done = 1'b1;
      end
      drive_inputs();
    end
  endtask

  task automatic clear_logs();
    order_log.delete();
    err_cnt = 0; beats0 = 0; beats1 = 0; beat_total = 0; exp_beats = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rq0.delete(); rq1.delete();
    s0_arvalid = 0; s1_arvalid = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0;
    m_rdata = '0; m_rresp = '0; s0_rready = 0; s1_rready = 0;
    mdl_out = 0; mdl_ar_done = 0; mdl_last = 1; mst_active = 0; last_hb = 0;
    ar_stall_left = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valids", {m_arvalid, m_rready, s0_rvalid, s1_rvalid}, 0);
    check("rst_arready", {s0_arready, s1_arready}, 0);
    check("rst_len_err", len_err, 0);
    @(posedge clk); #1;
  endtask

  vec_t vecs[8];

  initial begin
    rst = 1'b1;
    s0_arvalid = 0; s0_araddr = '0; s0_arlen = '0; s0_arsize = '0; s0_arburst = '0; s0_rready = 0;
    s1_arvalid = 0; s1_araddr = '0; s1_arlen = '0; s1_arsize = '0; s1_arburst = '0; s1_rready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_rlast = 0;
    rv_prob = 100; ar_prob = 100; rr_mode = 0; burst_no = 0; mst_idx = 0; mst_n = 0;
    cur_who = 0; cur_cnt = 0; cur = mk_req(32'h0, 0, 1);
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    //          rst v0 a0            l0 n0 v1 a1          l1 n1 stl rr  n o0 o1 err b0 b1
    vecs[0] = mkv(1, 1, 32'h0000_0100, 3, 4, 0, 32'h0,      0, 0, 0, 0, 1, 0, 0, 0, 4, 0);
    vecs[1] = mkv(1, 1, 32'hFFFE_0000, 0, 1, 1, 32'h40,     1, 2, 0, 0, 2, 0, 1, 0, 1, 2);
    vecs[2] = mkv(0, 1, 32'h0000_0200, 1, 2, 0, 32'h0,      0, 0, 0, 0, 1, 0, 0, 0, 2, 0);
    vecs[3] = mkv(0, 1, 32'h0000_0300, 2, 3, 1, 32'h380,    0, 1, 0, 0, 2, 1, 0, 0, 3, 1);
    vecs[4] = mkv(0, 0, 32'h0,         0, 0, 1, 32'h1000,   3, 4, 5, 1, 1, 1, 0, 0, 0, 4);
    vecs[5] = mkv(0, 1, 32'h0000_2000, 3, 2, 0, 32'h0,      0, 0, 0, 0, 1, 0, 0, 1, 2, 0);
    vecs[6] = mkv(0, 0, 32'h0,         0, 0, 1, 32'h3000,   1, 3, 0, 0, 1, 1, 0, 2, 0, 3);
    vecs[7] = mkv(0, 1, 32'h0000_4000, 0, 1, 1, 32'h5000,   0, 1, 0, 0, 2, 0, 1, 0, 1, 1);

    foreach (vecs[i]) begin
      if (vecs[i].pre_reset) do_reset();
      clear_logs();
      if (vecs[i].v0) rq0.push_back(mk_req(vecs[i].a0, vecs[i].l0, vecs[i].n0));
      if (vecs[i].v1) rq1.push_back(mk_req(vecs[i].a1, vecs[i].l1, vecs[i].n1));
      rr_mode = vecs[i].rr_mode; ar_stall_left = vecs[i].ar_stall;
      rv_prob = 100; ar_prob = 100;
      run_engine(400, 0, 0);
      check($sformatf("v%0d_grants", i), order_log.size(), vecs[i].exp_n);
      if (order_log.size() > 0) check($sformatf("v%0d_first", i), order_log[0], vecs[i].exp_o0);
      if (vecs[i].exp_n > 1 && order_log.size() > 1)
        check($sformatf("v%0d_second", i), order_log[1], vecs[i].exp_o1);
      check($sformatf("v%0d_len_err_pulses", i), err_cnt, vecs[i].exp_errs);
      check($sformatf("v%0d_s0_beats", i), beats0, vecs[i].exp_b0);
      check($sformatf("v%0d_s1_beats", i), beats1, vecs[i].exp_b1);
    end

    // Abort a burst mid-flight: the last completed grant is s0, so a reset
    // that fails to restore last_grant would hand the next tie to s1.
    clear_logs(); rr_mode = 0;
    rq0.push_back(mk_req(32'h0000_6000, 0, 1));
    run_engine(400, 0, 0);
    clear_logs();
    rq1.push_back(mk_req(32'h0000_7000, 3, 4));
    run_engine(400, 2, 0);
    check("abort_beats", beat_total, 2);
    do_reset();
    clear_logs(); rr_mode = 0;
    rq0.push_back(mk_req(32'h0000_8000, 1, 2));
    rq1.push_back(mk_req(32'h0000_9000, 0, 1));
    run_engine(400, 0, 0);
    check("post_rst_first", (order_log.size() > 0) ? order_log[0] : -1, 0);
    clear_logs();
    rq1.push_back(mk_req(32'h0000_A000, 2, 3));
    run_engine(400, 0, 0);
    check("post_rst_s1_grant", (order_log.size() > 0) ? order_log[0] : -1, 1);
    check("post_rst_s1_beats", beats1, 3);

    // randomized traffic with backpressure on every channel
    for (int round = 0; round < 3; round++) begin
      clear_logs();
      rr_mode = 2; rv_prob = 70; ar_prob = 60;
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        req_t r;
        r = rand_req(); rq0.push_back(r); exp_beats += r.nbeats;
        r = rand_req(); rq1.push_back(r); exp_beats += r.nbeats;
      end
      run_engine(20000, 0, 300);
      check($sformatf("rand%0d_beats", round), beat_total, exp_beats);
      check($sformatf("rand%0d_idle", round), busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
